// File: rtl/lineq_pkg.sv
// Shared constants and types for the lineq_solve datapath: matrix geometry,
// counter widths and the stream-loader state encoding.
package lineq_pkg;

  localparam int MAX_DIM   = 128;
  localparam int DATA_W    = 32;
  localparam int DIM_W     = 8;
  localparam int NUM_SLOTS = MAX_DIM * MAX_DIM;
  localparam int MAT_W     = NUM_SLOTS * DATA_W;
  localparam int CNT_W     = $clog2(NUM_SLOTS);
  localparam int TOT_W     = CNT_W + 1;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_LOAD = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  typedef enum logic [1:0] {
    IDLE = ST_IDLE,
    LOAD = ST_LOAD,
    DONE = ST_DONE
  } load_state_e;

  // A dimension is usable when it names at least one and at most MAX_DIM rows/columns.
  function automatic logic dim_legal(input logic [DIM_W-1:0] d);
    return (d != '0) && (int'(d) <= MAX_DIM);
  endfunction

endpackage

// File: rtl/matrix_stream_load.sv
// Collects a row-major stream of matrix elements into the flat matrix bus
// consumed by matrix_make, then issues a one-cycle make strobe.
module matrix_stream_load
  import lineq_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [DIM_W-1:0]  m_dim_in,
  input  logic [DIM_W-1:0]  n_dim_in,
  input  logic [DATA_W-1:0] data_in,
  input  logic              data_valid,
  output logic              data_ready,
  output logic              busy,
  output logic              err,
  output logic              make,
  output logic [DIM_W-1:0]  m1_dim,
  output logic [DIM_W-1:0]  n1_dim,
  output logic [MAT_W-1:0]  matrix1_out
);

  load_state_e                          state_q;
  logic [CNT_W-1:0]                     count_q;
  logic [TOT_W-1:0]                     total_q;
  logic                                 data_ready_q;
  logic                                 busy_q;
  logic                                 err_q;
  logic                                 make_q;
  logic [DIM_W-1:0]                     m_dim_q;
  logic [DIM_W-1:0]                     n_dim_q;
  logic [NUM_SLOTS-1:0][DATA_W-1:0]     mat_q;

  logic accept;
  logic last_word;
  logic start_ok;

  assign accept    = data_valid && data_ready_q;
  assign last_word = (TOT_W'(count_q) == (total_q - TOT_W'(1)));
  assign start_ok  = dim_legal(m_dim_in) && dim_legal(n_dim_in);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      count_q      <= '0;
      total_q      <= '0;
      data_ready_q <= 1'b0;
      busy_q       <= 1'b0;
      err_q        <= 1'b0;
      make_q       <= 1'b0;
      m_dim_q      <= '0;
      n_dim_q      <= '0;
      // NOTE: the element array is a flop bank, not a RAM, so it can and must
      // be reset: the output bus is required to read zero after reset.
      mat_q        <= '0;
    end else begin
      // NOTE: every state register uses non-blocking assignment so all of them
      // see the same pre-edge values regardless of statement order.
      err_q  <= 1'b0;
      make_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (start) begin
            if (start_ok) begin
              m_dim_q      <= m_dim_in;
              n_dim_q      <= n_dim_in;
              total_q      <= TOT_W'(m_dim_in) * TOT_W'(n_dim_in);
              count_q      <= '0;
              mat_q        <= '0;
              data_ready_q <= 1'b1;
              busy_q       <= 1'b1;
              state_q      <= LOAD;
            end else begin
              err_q <= 1'b1;
            end
          end
        end
        LOAD: begin
          // start is deliberately ignored here; only the stream advances the load.
          if (accept) begin
            mat_q[count_q] <= data_in;
            count_q        <= count_q + CNT_W'(1);
            if (last_word) begin
              data_ready_q <= 1'b0;
              make_q       <= 1'b1;
              state_q      <= DONE;
            end
          end
        end
        DONE: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign data_ready  = data_ready_q;
  assign busy        = busy_q;
  assign err         = err_q;
  assign make        = make_q;
  assign m1_dim      = m_dim_q;
  assign n1_dim      = n_dim_q;
  assign matrix1_out = mat_q;

endmodule
